// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared operation codes and FSM state encoding
// Holds the SEL operation constants and the IDLE/RUN/DONE state values
// used by digit_serial_adder.
package digit_serial_adder_pkg;
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_INC = 3'b010;
    localparam logic [2:0] SEL_DEC = 3'b011;
    localparam logic [2:0] SEL_DBL = 3'b100;
    localparam logic [2:0] SEL_NEG = 3'b101;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/digit_serial_adder_digit.sv
// adder_digit: combinational DIGIT-bit slice adder with carry in/out
// Ports: i_a, i_b  slice operands
//        i_ci      carry in
//        o_s       slice sum
//        o_co      carry out
module adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s,
    output logic             o_co
);
    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_ci};
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract unit processing DIGIT bits per cycle
// Ports: i_clk                     clock, rising edge
//        i_rst_n                   synchronous active-low reset
//        i_in_valid / o_in_ready   request handshake
//        i_in1, i_in2, i_sel       operands and operation select
//        o_out_valid / i_out_ready result handshake
//        o_out, o_flg              result and carry/borrow flag
//        o_zf                      zero flag, present only when DIGIT_SERIAL_ADDER_ZF_EN is defined
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [2:0]       i_sel,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_flg
`ifdef DIGIT_SERIAL_ADDER_ZF_EN
    ,
    output logic             o_zf
`endif
);
    localparam int NUMD = WIDTH / DIGIT;
    localparam int CW   = (NUMD > 1) ? $clog2(NUMD) : 1;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_acc_nx;
    logic             w_cin;
    logic             w_sub;
    logic             w_co;
    logic             w_last;
    logic [DIGIT-1:0] w_s;

    assign o_in_ready  = (r_state == ST_IDLE) && i_rst_n;
    assign o_out_valid = (r_state == ST_DONE);
    assign w_last      = (r_cnt == CW'(NUMD - 1));

    // Every op is mapped onto a + b + cin; subtracts use the inverted
    // operand with cin=1 and report borrow as the inverted carry-out.
    always_comb begin
        w_a = (i_sel == SEL_NEG) ? '0 : i_in1;
        w_b = (i_sel == SEL_ADD) ? i_in2 :
              (i_sel == SEL_SUB) ? ~i_in2 :
              (i_sel == SEL_DEC) ? ~WIDTH'(1) :
              (i_sel == SEL_DBL) ? i_in1 :
              (i_sel == SEL_NEG) ? ~i_in1 : '0;
        w_sub = (i_sel == SEL_SUB) || (i_sel == SEL_DEC) || (i_sel == SEL_NEG);
        w_cin = w_sub || (i_sel == SEL_INC);
        w_acc_nx = r_acc;
        w_acc_nx[r_cnt*DIGIT +: DIGIT] = w_s;
    end

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a  (r_a[r_cnt*DIGIT +: DIGIT]),
        .i_b  (r_b[r_cnt*DIGIT +: DIGIT]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            o_out   <= '0;
            o_flg   <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_ZF_EN
            o_zf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (i_in_valid) begin
                    r_a     <= w_a;
                    r_b     <= w_b;
                    r_carry <= w_cin;
                    r_sub   <= w_sub;
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_acc   <= w_acc_nx;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_out   <= w_acc_nx;
                        o_flg   <= w_co ^ r_sub;
`ifdef DIGIT_SERIAL_ADDER_ZF_EN
                        o_zf    <= (w_acc_nx == '0);
`endif
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: if (i_out_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4)
module tb_digit_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic [2:0]  sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic        flg;
`ifdef DIGIT_SERIAL_ADDER_ZF_EN
    logic        zf;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in1       (in1),
        .i_in2       (in2),
        .i_sel       (sel),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out       (out),
        .o_flg       (flg)
`ifdef DIGIT_SERIAL_ADDER_ZF_EN
        ,
        .o_zf        (zf)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one request, checks latency (OUT_VALID after the 5th edge
    // counting the accept edge), then the result; optionally releases DONE.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eo, input logic ef,
                          input bit scramble, input bit rel);
        logic [15:0] prev;
        prev = out;
        chk({tag, " in_ready idle"}, in_ready, 1);
        sel = s; in1 = a; in2 = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " latency"}, out_valid, 0);
            if (i == 0) chk({tag, " out held"}, out, prev);
            if (scramble) begin
                in1 = 16'($urandom); in2 = 16'($urandom); sel = 3'($urandom);
            end
            step();
        end
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " out"}, out, eo);
        chk({tag, " flg"}, flg, ef);
`ifdef DIGIT_SERIAL_ADDER_ZF_EN
        chk({tag, " zf"}, zf, eo == 16'h0);
`endif
        if (rel) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk({tag, " in_ready after release"}, in_ready, 1);
            chk({tag, " out_valid after release"}, out_valid, 0);
        end
    endtask

    initial begin
        step();
        step();
        chk("reset out", out, 0);
        chk("reset flg", flg, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", in_ready, 1);

        run_op("add ffff+1", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, 1);
        run_op("sub 3-5",    3'b001, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 0, 1);
        run_op("sub 5-3",    3'b001, 16'h0005, 16'h0003, 16'h0002, 1'b0, 0, 1);
        run_op("dbl 8001",   3'b100, 16'h8001, 16'h1234, 16'h0002, 1'b1, 0, 1);
        run_op("neg 1",      3'b101, 16'h0001, 16'h0000, 16'hFFFF, 1'b1, 0, 1);
        run_op("neg 0",      3'b101, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 1);
        run_op("dec 0",      3'b011, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 0, 1);
        run_op("inc ffff",   3'b010, 16'hFFFF, 16'h5555, 16'h0000, 1'b1, 0, 1);
        run_op("inc 1234",   3'b010, 16'h1234, 16'h0000, 16'h1235, 1'b0, 0, 1);
        run_op("pass 110",   3'b110, 16'hA5A5, 16'hFFFF, 16'hA5A5, 1'b0, 0, 1);
        run_op("pass 111",   3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1);
        run_op("add scramble", 3'b000, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1, 1);
        run_op("sub scramble", 3'b001, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1, 1);
        run_op("add carry chain", 3'b000, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 0, 1);

        run_op("hold add", 3'b000, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 0, 0);
        in_valid = 1'b1; sel = 3'b010; in1 = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold out_valid", out_valid, 1);
            chk("hold out", out, 16'hFFFE);
            chk("hold flg", flg, 0);
            chk("hold in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold release in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) step();
        chk("ignored request not queued", out_valid, 0);
        chk("idle keeps out", out, 16'hFFFE);

        sel = 3'b000; in1 = 16'h0001; in2 = 16'h0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("in_ready during reset", in_ready, 0);
        step();
        chk("abort out_valid", out_valid, 0);
        chk("abort out", out, 0);
        chk("abort flg", flg, 0);
        rst_n = 1'b1;
        #1;
        chk("abort in_ready after release", in_ready, 1);
        for (int i = 0; i < 6; i++) step();
        chk("abort no result", out_valid, 0);
        run_op("after abort", 3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per cycle; WIDTH SHALL be a positive multiple of DIGIT; NUMD = WIDTH/DIGIT.
REQ-003 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports IN_VALID input 1 and IN_READY output 1, request handshake.
REQ-006 SHALL have ports IN1 input WIDTH and IN2 input WIDTH, operands.
REQ-007 SHALL have port SEL  input  3  operation select.
REQ-008 SHALL have ports OUT_VALID output 1 and OUT_READY input 1, result handshake.
REQ-009 SHALL have port OUT  output  WIDTH  result.
REQ-010 SHALL have port FLG  output  1  carry (add ops) or borrow (subtract ops).

Function
REQ-011 SEL codes SHALL be: 000 ADD IN1+IN2; 001 SUB IN1-IN2; 010 INC IN1+1; 011 DEC IN1-1; 100 DBL IN1+IN1; 101 NEG 0-IN1; 110/111 PASS OUT=IN1, FLG=0.
REQ-012 Subtract ops (SUB, DEC, NEG) SHALL use inverted second operand plus carry-in 1; FLG SHALL be final carry-out XOR 1 (1 = borrow).
REQ-013 Add ops SHALL report FLG = carry-out of bit WIDTH-1; all arithmetic modulo 2^WIDTH.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: IN_READY=1; on IN_VALID=1 at a rising edge, capture IN1, second operand, SEL, carry-in; clear digit counter; go RUN.
REQ-016 RUN: each cycle add one DIGIT slice, LSB slice first, propagating carry in a register; after NUMD RUN cycles go DONE.
REQ-017 Latency SHALL be exactly NUMD+1 edges from the accept edge to OUT_VALID=1 observed; WIDTH==DIGIT gives 2.
REQ-018 Captured operands SHALL be unaffected by IN1/IN2/SEL changes after acceptance.
REQ-019 DONE: OUT_VALID=1, OUT and FLG stable; on OUT_READY=1 go IDLE; OUT_READY low SHALL hold DONE indefinitely.
REQ-020 IN_READY SHALL be 0 in RUN and DONE; no new request accepted in the DONE->IDLE edge cycle.
REQ-021 OUT and FLG SHALL retain last result in IDLE and RUN until the next DONE overwrites them.
REQ-022 IN_VALID while IN_READY=0 SHALL be ignored, not queued.

Reset
REQ-023 RST_N=0 at a rising edge SHALL force IDLE, OUT=0, FLG=0, OUT_VALID=0, carry and counter 0.
REQ-024 IN_READY SHALL be 0 while RST_N=0.
REQ-025 Reset during RUN or DONE SHALL abort the operation; no result is delivered.

Configuration
REQ-026 Macro DIGIT_SERIAL_ADDER_ZF_EN defined: output port ZF (1 bit) SHALL exist, equal 1 when OUT==0, registered with OUT, reset 0.
REQ-027 Macro undefined: no ZF port and no zero-detect logic; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold SEL operation code constants and FSM state encoding.
REQ-029 One sub-module adder_digit SHALL implement the combinational DIGIT-bit slice add with carry-in/carry-out, instantiated once.

Verification (WIDTH=16, DIGIT=4)
REQ-030 ADD 0xFFFF+0x0001 -> OUT_VALID after 5 edges, OUT=0x0000, FLG=1, ZF=1 if enabled.
REQ-031 SUB 0x0003-0x0005 -> OUT=0xFFFE, FLG=1; SUB 0x0005-0x0003 -> OUT=0x0002, FLG=0.
REQ-032 DBL 0x8001 -> OUT=0x0002, FLG=1; NEG 0x0001 -> OUT=0xFFFF, FLG=1; DEC 0x0000 -> OUT=0xFFFF, FLG=1.
REQ-033 OUT_READY held 0 for 3 cycles in DONE -> OUT_VALID, OUT, FLG unchanged; IN_VALID ignored; IN_READY=1 the cycle after OUT_READY=1.
REQ-034 RST_N=0 on second RUN cycle -> next cycle IDLE, OUT_VALID=0, OUT=0; IN_READY=1 once RST_N=1.
REQ-035 Operands changed every cycle during RUN -> result matches values captured at accept.
